muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 32, meaning operand and result width, an even number of at least 8.
REQ-002 The block SHALL have parameter AWIDTH, default 5, meaning destination register address width.
REQ-003 The block SHALL have parameter FUNCT_WIDTH, default 3, meaning operation select width.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 The block SHALL have port mdu_clk  in  1  clock, rising edge.
REQ-006 The block SHALL have port mdu_rst  in  1  asynchronous active-low reset.
REQ-007 The block SHALL have port mdu_i_ce  in  1  request valid.
REQ-008 The block SHALL have port mdu_i_flush  in  1  abort the current or incoming operation.
REQ-009 The block SHALL have port mdu_i_funct3  in  FUNCT_WIDTH  operation select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-010 The block SHALL have port mdu_i_data_rs1  in  DWIDTH  operand a, the multiplicand or dividend.
REQ-011 The block SHALL have port mdu_i_data_rs2  in  DWIDTH  operand b, the multiplier or divisor.
REQ-012 The block SHALL have port mdu_i_addr_rd  in  AWIDTH  destination register address.
REQ-013 The block SHALL have port mdu_o_stall  out  1  busy indication; the upstream stage holds while this is high.
REQ-014 The block SHALL have port mdu_o_valid  out  1  one-cycle result strobe.
REQ-015 The block SHALL have port mdu_o_we_reg  out  1  register-file write enable, qualified by mdu_o_valid.
REQ-016 The block SHALL have port mdu_o_addr_rd  out  AWIDTH  destination address of the result.
REQ-017 The block SHALL have port mdu_o_data_rd  out  DWIDTH  result data.

Function
REQ-018 The FSM SHALL have the states IDLE, MUL, DIV and DONE; only IDLE accepts requests.
REQ-019 A request SHALL be accepted at a rising edge where the state is IDLE, mdu_i_ce is 1 and mdu_i_flush is 0; the block SHALL capture the operands, funct3 and rd at that edge.
REQ-020 For funct3 0-3, acceptance SHALL go to MUL; a shift-add loop SHALL run for DWIDTH cycles on a 2*DWIDTH-bit product register, then go to DONE.
REQ-021 For funct3 4-7, acceptance SHALL go to DIV; a restoring loop SHALL produce one quotient bit per cycle for DWIDTH cycles, then go to DONE.
REQ-022 For the signed operations, operands SHALL be converted to magnitudes at accept and the result sign SHALL be fixed in DONE. DIV gives the quotient the sign of a XOR b; REM gives the remainder the sign of a; MULHSU treats a as signed and b as unsigned.
REQ-023 Result selection SHALL be: MUL returns the product bits [DWIDTH-1:0]; MULH, MULHSU and MULHU return bits [2*DWIDTH-1:DWIDTH].
REQ-024 For division by zero (b==0), the block SHALL go from accept directly to DONE; the quotient SHALL be all ones and the remainder SHALL equal a.
REQ-025 For signed overflow (DIV or REM with a==most-negative and b==all ones), the block SHALL go directly to DONE; the quotient SHALL equal a and the remainder SHALL be 0.
REQ-026 In DONE, the block SHALL register mdu_o_valid=1, mdu_o_data_rd, mdu_o_addr_rd, and mdu_o_we_reg=(rd!=0) for exactly one cycle, then return to IDLE.
REQ-027 mdu_o_valid and mdu_o_we_reg SHALL be 0 in every cycle other than the one following the DONE state.
REQ-028 mdu_o_data_rd and mdu_o_addr_rd SHALL hold their last values while mdu_o_valid is 0.
REQ-029 mdu_o_stall SHALL be 1 exactly while the state is MUL or DIV, plus during the DONE state.
REQ-030 Latency for an iterative operation accepted at edge k SHALL be: mdu_o_valid high in the cycle after edge k+DWIDTH+1. Latency for the fast paths (REQ-024, REQ-025) SHALL be: mdu_o_valid high in the cycle after edge k+2.
REQ-031 Flush in any state SHALL force IDLE at that edge and suppress the pending mdu_o_valid.
REQ-032 Flush together with mdu_i_ce in IDLE SHALL take precedence: no accept.
REQ-033 mdu_i_ce while not IDLE SHALL be ignored, with no queuing.
REQ-034 The iteration counter SHALL be clog2(DWIDTH)+1 bits and SHALL never wrap during an operation.

Reset
REQ-035 On mdu_rst low, the block SHALL asynchronously go to IDLE with the counter, product register, quotient register and remainder register cleared.
REQ-036 During reset, mdu_o_stall, mdu_o_valid and mdu_o_we_reg SHALL be 0.
REQ-037 During reset, mdu_o_addr_rd SHALL be 0 and mdu_o_data_rd SHALL be 0.
REQ-038 Reset asserted mid-operation SHALL abandon the operation; no result SHALL be emitted after release.

Configuration
REQ-039 Macro MDU_FAST_MUL_EN SHALL select the multiply implementation.
REQ-040 With MDU_FAST_MUL_EN defined, funct3 0-3 SHALL be computed in one cycle by a single 2*DWIDTH-bit combinational product. The block SHALL go from accept directly to DONE, with mdu_o_valid in the cycle after edge k+2. Division SHALL be unchanged.
REQ-041 Without MDU_FAST_MUL_EN, multiplies SHALL use the iterative MUL state per REQ-020 and REQ-030.

Verification
REQ-042 MUL with a=7, b=-3 (0xFFFFFFFD) and rd=5 SHALL give data 0xFFFFFFEB and we_reg=1, with valid 34 cycles after accept (3 with MDU_FAST_MUL_EN).
REQ-043 MULH with a=0x80000000, b=0x80000000 SHALL give 0x40000000; MULHU with the same operands SHALL give 0x40000000; MULHSU with a=-1, b=0xFFFFFFFF SHALL give 0xFFFFFFFF.
REQ-044 DIV -7/2 SHALL give -3 (0xFFFFFFFD); REM -7/2 SHALL give -1; DIVU 100/7 SHALL give 14; REMU 100/7 SHALL give 2.
REQ-045 DIV 5/0 SHALL give 0xFFFFFFFF; REM 5/0 SHALL give 5; DIV 0x80000000/-1 SHALL give 0x80000000; REM with the same operands SHALL give 0; each SHALL have valid 3 cycles after accept.
REQ-046 Flush asserted 10 cycles into a DIVU SHALL leave stall low on the next cycle and emit no valid. A new request issued immediately afterwards SHALL complete correctly.
REQ-047 A second ce asserted while busy SHALL be ignored. With rd=0, valid SHALL be 1 and we_reg 0. Reset asserted mid-MUL SHALL leave all outputs at 0 and emit no result after release.

Source files
------------

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// This is a multiply/divide unit for an integer execution stage. It performs
// the eight RV32M-style operations selected by mdu_i_funct3:
//   0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//
// Multiplies use a shift-add loop on a 2*DWIDTH-bit product register.
// Divides use a restoring loop that produces one quotient bit per cycle.
// Signed operands are reduced to magnitudes when a request is accepted. The
// result sign is restored in the DONE state. Division by zero and signed
// overflow do not run the loop; they skip it and go straight to DONE.
//
// Configuration macro:
//   MDU_FAST_MUL_EN - when defined, multiplies use one combinational
//                     2*DWIDTH-bit product and skip the iterative loop.
//
// Parameters:
//   DWIDTH      - operand and result width (even, >= 8)
//   AWIDTH      - destination register address width
//   FUNCT_WIDTH - operation select width (the low three bits are decoded)
//
// Ports:
//   mdu_clk        in   clock, rising edge
//   mdu_rst        in   asynchronous reset, active low
//   mdu_i_ce       in   request valid (accepted only in IDLE)
//   mdu_i_flush    in   abort the current or incoming operation
//   mdu_i_funct3   in   operation select
//   mdu_i_data_rs1 in   operand a (multiplicand / dividend)
//   mdu_i_data_rs2 in   operand b (multiplier / divisor)
//   mdu_i_addr_rd  in   destination register address
//   mdu_o_stall    out  high while an operation is in flight
//   mdu_o_valid    out  one-cycle result strobe
//   mdu_o_we_reg   out  register-file write enable (rd != 0), with valid
//   mdu_o_addr_rd  out  destination address of the result
//   mdu_o_data_rd  out  result data
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int DWIDTH      = 32,
    parameter int AWIDTH      = 5,
    parameter int FUNCT_WIDTH = 3
) (
    input  logic                   mdu_clk,
    input  logic                   mdu_rst,
    input  logic                   mdu_i_ce,
    input  logic                   mdu_i_flush,
    input  logic [FUNCT_WIDTH-1:0] mdu_i_funct3,
    input  logic [DWIDTH-1:0]      mdu_i_data_rs1,
    input  logic [DWIDTH-1:0]      mdu_i_data_rs2,
    input  logic [AWIDTH-1:0]      mdu_i_addr_rd,
    output logic                   mdu_o_stall,
    output logic                   mdu_o_valid,
    output logic                   mdu_o_we_reg,
    output logic [AWIDTH-1:0]      mdu_o_addr_rd,
    output logic [DWIDTH-1:0]      mdu_o_data_rd
);

    localparam int P_W   = 2 * DWIDTH;
    localparam int CNT_W = $clog2(DWIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Two's-complement sign restoration for single- and double-width values
    function automatic logic [DWIDTH-1:0] apply_sign_w(input logic [DWIDTH-1:0] mag,
                                                       input logic neg);
        return neg ? -mag : mag;
    endfunction

    function automatic logic [P_W-1:0] apply_sign_2w(input logic [P_W-1:0] mag,
                                                     input logic neg);
        return neg ? -mag : mag;
    endfunction

    state_t              state_q, state_d;

    logic [2:0]          op_q;
    logic [AWIDTH-1:0]   rd_q;
    logic                neg_q;
    logic                hold_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DWIDTH-1:0]   opnd_q;   // multiplicand magnitude, or divisor magnitude
    logic [P_W-1:0]      prod_q;
    logic [DWIDTH-1:0]   quo_q;
    logic [DWIDTH-1:0]   rem_q;

    // ---------------------------------------------------------------------
    // Request decode (combinational, used at the accept edge)
    // ---------------------------------------------------------------------
    logic [2:0]               op_in;
    logic                     in_is_div;
    logic                     a_sgn_en, b_sgn_en;
    logic                     a_neg_in, b_neg_in;
    logic signed [DWIDTH-1:0] rs1_s, rs2_s;
    logic [DWIDTH-1:0]        a_mag_in, b_mag_in;
    logic                     div_zero_in, div_ovf_in, fast_div_in;
    logic                     neg_in;
    logic                     accept;
    logic                     cnt_last;

    assign op_in     = mdu_i_funct3[2:0];
    assign in_is_div = op_in[2];
    assign rs1_s     = mdu_i_data_rs1;
    assign rs2_s     = mdu_i_data_rs2;

    // a is signed for MULH, MULHSU, DIV and REM; b for MULH, DIV and REM
    assign a_sgn_en = (op_in == 3'd1) || (op_in == 3'd2) || (op_in == 3'd4) || (op_in == 3'd6);
    assign b_sgn_en = (op_in == 3'd1) || (op_in == 3'd4) || (op_in == 3'd6);
    assign a_neg_in = a_sgn_en && (rs1_s < 0);
    assign b_neg_in = b_sgn_en && (rs2_s < 0);
    assign a_mag_in = a_neg_in ? -mdu_i_data_rs1 : mdu_i_data_rs1;
    assign b_mag_in = b_neg_in ? -mdu_i_data_rs2 : mdu_i_data_rs2;

    assign div_zero_in = (mdu_i_data_rs2 == '0);
    assign div_ovf_in  = ((op_in == 3'd4) || (op_in == 3'd6))
                       && (mdu_i_data_rs1 == {1'b1, {(DWIDTH-1){1'b0}}})
                       && (mdu_i_data_rs2 == '1);
    assign fast_div_in = in_is_div && (div_zero_in || div_ovf_in);

    // Remainder takes the sign of a; quotient and products take a XOR b
    assign neg_in = ((op_in == 3'd6) || (op_in == 3'd7)) ? a_neg_in : (a_neg_in ^ b_neg_in);

    assign accept   = (state_q == S_IDLE) && mdu_i_ce && !mdu_i_flush;
    assign cnt_last = (cnt_q == CNT_W'(DWIDTH - 1));

`ifdef MDU_FAST_MUL_EN
    logic [P_W-1:0] prod_fast;
    assign prod_fast = P_W'(a_mag_in) * P_W'(b_mag_in);
`endif

    // ---------------------------------------------------------------------
    // Iteration steps
    // ---------------------------------------------------------------------
    logic [DWIDTH:0]   mul_sum;
    logic [P_W-1:0]    prod_n;
    logic [DWIDTH:0]   rem_sh, rem_diff;
    logic [DWIDTH-1:0] quo_n, rem_n;

    always_comb begin
        mul_sum = {1'b0, prod_q[P_W-1:DWIDTH]} + {1'b0, (prod_q[0] ? opnd_q : {DWIDTH{1'b0}})};
        prod_n  = {mul_sum, prod_q[DWIDTH-1:1]};
    end

    // A borrow out of rem_diff (its top bit) means the trial subtraction fails
    always_comb begin
        rem_sh   = {rem_q, quo_q[DWIDTH-1]};
        rem_diff = rem_sh - {1'b0, opnd_q};
        if (!rem_diff[DWIDTH]) begin
            rem_n = rem_diff[DWIDTH-1:0];
            quo_n = {quo_q[DWIDTH-2:0], 1'b1};
        end else begin
            rem_n = rem_sh[DWIDTH-1:0];
            quo_n = {quo_q[DWIDTH-2:0], 1'b0};
        end
    end

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge mdu_clk or negedge mdu_rst) begin
        if (!mdu_rst) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // ---------------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (mdu_i_flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mdu_i_ce) begin
                        if (in_is_div) begin
                            state_d = fast_div_in ? S_DONE : S_DIV;
                        end else begin
`ifdef MDU_FAST_MUL_EN
                            state_d = S_DONE;
`else
                            state_d = S_MUL;
`endif
                        end
                    end
                end
                S_MUL:   if (cnt_last) state_d = S_DONE;
                S_DIV:   if (cnt_last) state_d = S_DONE;
                S_DONE:  if (!hold_q)  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------
    logic emit;

    always_comb begin
        mdu_o_stall = (state_q != S_IDLE);
        emit        = (state_q == S_DONE) && !hold_q && !mdu_i_flush;
    end

    // ---------------------------------------------------------------------
    // Operand capture and iteration registers
    // ---------------------------------------------------------------------
    // hold_q keeps a skip-loop operation in DONE for one extra cycle. This
    // gives every skip-loop result the same fixed two-edge latency.
    always_ff @(posedge mdu_clk or negedge mdu_rst) begin
        if (!mdu_rst) begin
            op_q   <= '0;
            rd_q   <= '0;
            neg_q  <= 1'b0;
            hold_q <= 1'b0;
            cnt_q  <= '0;
            opnd_q <= '0;
            prod_q <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
        end else if (accept) begin
            op_q  <= op_in;
            rd_q  <= mdu_i_addr_rd;
            cnt_q <= '0;
            if (in_is_div) begin
                opnd_q <= b_mag_in;
                hold_q <= fast_div_in;
                if (div_zero_in) begin
                    neg_q <= 1'b0;
                    quo_q <= '1;
                    rem_q <= mdu_i_data_rs1;
                end else if (div_ovf_in) begin
                    neg_q <= 1'b0;
                    quo_q <= mdu_i_data_rs1;
                    rem_q <= '0;
                end else begin
                    neg_q <= neg_in;
                    quo_q <= a_mag_in;
                    rem_q <= '0;
                end
            end else begin
                neg_q  <= neg_in;
                opnd_q <= a_mag_in;
`ifdef MDU_FAST_MUL_EN
                hold_q <= 1'b1;
                prod_q <= prod_fast;
`else
                hold_q <= 1'b0;
                prod_q <= {{DWIDTH{1'b0}}, b_mag_in};
`endif
            end
        end else begin
            case (state_q)
                S_MUL: begin
                    prod_q <= prod_n;
                    cnt_q  <= cnt_q + CNT_W'(1);
                end
                S_DIV: begin
                    quo_q <= quo_n;
                    rem_q <= rem_n;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                S_DONE:  hold_q <= 1'b0;
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Result selection with sign restoration
    // ---------------------------------------------------------------------
    logic [P_W-1:0]    prod_full;
    logic [DWIDTH-1:0] result_w;

    always_comb begin
        prod_full = apply_sign_2w(prod_q, neg_q);
        result_w  = '0;
        if (op_q[2]) begin
            result_w = op_q[1] ? apply_sign_w(rem_q, neg_q) : apply_sign_w(quo_q, neg_q);
        end else if (op_q[1:0] == 2'd0) begin
            result_w = prod_full[DWIDTH-1:0];
        end else begin
            result_w = prod_full[P_W-1:DWIDTH];
        end
    end

    // ---------------------------------------------------------------------
    // Output register: strobe for one cycle, data/address hold otherwise
    // ---------------------------------------------------------------------
    always_ff @(posedge mdu_clk or negedge mdu_rst) begin
        if (!mdu_rst) begin
            mdu_o_valid   <= 1'b0;
            mdu_o_we_reg  <= 1'b0;
            mdu_o_addr_rd <= '0;
            mdu_o_data_rd <= '0;
        end else if (emit) begin
            mdu_o_valid   <= 1'b1;
            mdu_o_we_reg  <= (rd_q != '0);
            mdu_o_addr_rd <= rd_q;
            mdu_o_data_rd <= result_w;
        end else begin
            mdu_o_valid  <= 1'b0;
            mdu_o_we_reg <= 1'b0;
        end
    end

endmodule
